// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller.
// Imported by the controller and its memory array.
package sync_fifo_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;

    // Bit positions of the flags on the monitor status bus
    localparam int STAT_FULL   = 0;
    localparam int STAT_EMPTY  = 1;
    localparam int STAT_AFULL  = 2;
    localparam int STAT_AEMPTY = 3;
    localparam int STAT_OVF    = 4;
    localparam int STAT_UDF    = 5;
    localparam int STAT_W      = 6;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/fifo_mem_array.sv
// DEPTH x DATA_WIDTH dual-port storage with a synchronous write port.
// The read port is registered; only that output register is reset.
module fifo_mem_array
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Same-address read and write returns the old word
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Parametrised synchronous FIFO: pointers, occupancy, status flags
// and sticky error flags around fifo_mem_array.
module sync_fifo_ctrl
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
    parameter int ALMOST_FULL_LEVEL  = 6,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_Enable,
    input  logic [DATA_WIDTH-1:0] buffer_Input,
    input  logic                  read_Enable,
    output logic [DATA_WIDTH-1:0] buffer_Output,
    output logic                  read_Valid,
    output logic                  sig_Full,
    output logic                  sig_Empty,
    output logic                  sig_Almost_Full,
    output logic                  sig_Almost_Empty,
    output logic [ADDR_WIDTH:0]   fill_Count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear_Errors
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(depth_of(ADDR_WIDTH));
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_LEVEL);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count_next;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  wr_rej;
    logic                  rd_rej;
    logic                  mem_wr;
    logic                  mem_rd;

    // Acceptance uses flags registered before the edge, so a read
    // never frees a slot for the same cycle's write
    always_comb begin
        wr_acc = write_Enable & ~sig_Full;
        rd_acc = read_Enable & ~sig_Empty;
        wr_rej = write_Enable & sig_Full;
        rd_rej = read_Enable & sig_Empty;
        mem_wr = wr_acc & ~reset;
        mem_rd = rd_acc & ~reset;
    end

    always_comb begin
        count_next = fill_Count;
        unique case (1'b1)
            (wr_acc & ~rd_acc): count_next = fill_Count + 1'b1;
            (rd_acc & ~wr_acc): count_next = fill_Count - 1'b1;
            default:            count_next = fill_Count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            fill_Count       <= '0;
            sig_Full         <= 1'b0;
            sig_Empty        <= 1'b1;
            sig_Almost_Full  <= 1'b0;
            sig_Almost_Empty <= 1'b1;
            read_Valid       <= 1'b0;
            overflow         <= 1'b0;
            underflow        <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fill_Count       <= count_next;
            sig_Full         <= (count_next == DEPTH_C);
            sig_Empty        <= (count_next == '0);
            sig_Almost_Full  <= (count_next >= AF_C);
            sig_Almost_Empty <= (count_next <= AE_C);
            read_Valid       <= rd_acc;
            overflow         <= wr_rej | (overflow & ~clear_Errors);
            underflow        <= rd_rej | (underflow & ~clear_Errors);
        end
    end

    fifo_mem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (mem_wr),
        .wr_addr(wr_ptr),
        .wr_data(buffer_Input),
        .rd_en  (mem_rd),
        .rd_addr(rd_ptr),
        .rd_data(buffer_Output)
    );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: read data goes through a scoreboard
// queue checked by a monitor, flags are checked directly.
module tb_sync_fifo_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       write_Enable;
    logic [7:0] buffer_Input;
    logic       read_Enable;
    logic [7:0] buffer_Output;
    logic       read_Valid;
    logic       sig_Full;
    logic       sig_Empty;
    logic       sig_Almost_Full;
    logic       sig_Almost_Empty;
    logic [3:0] fill_Count;
    logic       overflow;
    logic       underflow;
    logic       clear_Errors;

    int checks   = 0;
    int failures = 0;
    int pushed   = 0;
    int strobes  = 0;
    logic [7:0] exp_q[$];

    sync_fifo_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .write_Enable    (write_Enable),
        .buffer_Input    (buffer_Input),
        .read_Enable     (read_Enable),
        .buffer_Output   (buffer_Output),
        .read_Valid      (read_Valid),
        .sig_Full        (sig_Full),
        .sig_Empty       (sig_Empty),
        .sig_Almost_Full (sig_Almost_Full),
        .sig_Almost_Empty(sig_Almost_Empty),
        .fill_Count      (fill_Count),
        .overflow        (overflow),
        .underflow       (underflow),
        .clear_Errors    (clear_Errors)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every read_Valid strobe must match the oldest expected word
    always @(negedge clock) begin
        if (read_Valid === 1'b1) begin
            strobes++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got %0h expected none",
                         buffer_Output);
            end else begin
                chk("rd_data", {24'd0, buffer_Output}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
        write_Enable = 1'b0;
        read_Enable  = 1'b0;
        clear_Errors = 1'b0;
        reset        = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        write_Enable = 1'b1;
        buffer_Input = d;
        tick();
    endtask

    task automatic rd(input logic [7:0] d);
        read_Enable = 1'b1;
        exp_q.push_back(d);
        pushed++;
        tick();
    endtask

    task automatic rw(input logic [7:0] wd, input logic [7:0] rdat);
        write_Enable = 1'b1;
        buffer_Input = wd;
        read_Enable  = 1'b1;
        exp_q.push_back(rdat);
        pushed++;
        tick();
    endtask

    task automatic chk_flags(input string name, input int cnt,
                             input logic f, input logic e,
                             input logic af, input logic ae);
        chk({name, "_cnt"}, {28'd0, fill_Count}, cnt);
        chk({name, "_full"}, {31'd0, sig_Full}, {31'd0, f});
        chk({name, "_empty"}, {31'd0, sig_Empty}, {31'd0, e});
        chk({name, "_afull"}, {31'd0, sig_Almost_Full}, {31'd0, af});
        chk({name, "_aempty"}, {31'd0, sig_Almost_Empty}, {31'd0, ae});
    endtask

    initial begin
        reset        = 1'b1;
        write_Enable = 1'b0;
        read_Enable  = 1'b0;
        clear_Errors = 1'b0;
        buffer_Input = 8'h00;
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk_flags("rst", 0, 0, 1, 0, 1);
        chk("rst_out", {24'd0, buffer_Output}, 32'h0);
        chk("rst_rv", {31'd0, read_Valid}, 32'h0);
        chk("rst_ovf", {31'd0, overflow}, 32'h0);
        chk("rst_udf", {31'd0, underflow}, 32'h0);

        // Fill 0x11..0x18
        for (int i = 0; i < 8; i++) begin
            wr(8'h11 + 8'(i));
            chk_flags("fill", i + 1, (i == 7), 0, (i >= 5), (i <= 1));
        end
        wr(8'hFF);
        chk("ovf_set", {31'd0, overflow}, 32'h1);
        chk_flags("ovf", 8, 1, 0, 1, 0);
        // Clear with concurrent overflow: set wins
        write_Enable = 1'b1;
        buffer_Input = 8'hFE;
        clear_Errors = 1'b1;
        tick();
        chk("clr_vs_ovf", {31'd0, overflow}, 32'h1);
        clear_Errors = 1'b1;
        tick();
        chk("clr_ovf", {31'd0, overflow}, 32'h0);

        // Drain; rejected writes must not have touched memory
        for (int i = 0; i < 8; i++) begin
            rd(8'h11 + 8'(i));
            chk_flags("drain", 7 - i, 0, (i == 7), (i <= 1), (i >= 5));
        end
        read_Enable = 1'b1;
        tick();
        chk("udf_set", {31'd0, underflow}, 32'h1);
        chk("udf_rv", {31'd0, read_Valid}, 32'h0);
        chk("udf_hold", {24'd0, buffer_Output}, 32'h18);
        chk_flags("udf", 0, 0, 1, 0, 1);
        clear_Errors = 1'b1;
        tick();
        chk("clr_udf", {31'd0, underflow}, 32'h0);

        // Wrap: fill 5, drain 5, then a 1..2 entry backlog
        for (int i = 0; i < 5; i++) wr(8'h21 + 8'(i));
        chk("wrap_fill", {28'd0, fill_Count}, 32'd5);
        for (int i = 0; i < 5; i++) rd(8'h21 + 8'(i));
        wr(8'h30);
        for (int i = 0; i < 9; i++) begin
            wr(8'h31 + 8'(i));
            chk("wrap_cnt2", {28'd0, fill_Count}, 32'd2);
            rd(8'h30 + 8'(i));
            chk("wrap_cnt1", {28'd0, fill_Count}, 32'd1);
        end
        rd(8'h39);
        chk_flags("wrap_end", 0, 0, 1, 0, 1);

        // Simultaneous read+write at 4, 8 and 0
        for (int i = 0; i < 4; i++) wr(8'h41 + 8'(i));
        rw(8'h45, 8'h41);
        chk_flags("rw4", 4, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) wr(8'h46 + 8'(i));
        chk("rw8_pre", {28'd0, fill_Count}, 32'd8);
        rw(8'hEE, 8'h42);
        chk_flags("rw8", 7, 0, 0, 1, 0);
        chk("rw8_ovf", {31'd0, overflow}, 32'h1);
        for (int i = 0; i < 7; i++) rd(8'h43 + 8'(i));
        chk("rw0_pre", {28'd0, fill_Count}, 32'd0);
        write_Enable = 1'b1;
        buffer_Input = 8'h50;
        read_Enable  = 1'b1;
        tick();
        chk_flags("rw0", 1, 0, 0, 0, 1);
        chk("rw0_udf", {31'd0, underflow}, 32'h1);
        chk("rw0_rv", {31'd0, read_Valid}, 32'h0);
        rd(8'h50);

        // Reset mid-operation with a read requested: reset wins
        for (int i = 0; i < 5; i++) wr(8'h61 + 8'(i));
        chk("pre_rst_cnt", {28'd0, fill_Count}, 32'd5);
        read_Enable = 1'b1;
        reset       = 1'b1;
        tick();
        chk_flags("mid_rst", 0, 0, 1, 0, 1);
        chk("mid_rst_rv", {31'd0, read_Valid}, 32'h0);
        chk("mid_rst_out", {24'd0, buffer_Output}, 32'h0);
        chk("mid_rst_ovf", {31'd0, overflow}, 32'h0);
        chk("mid_rst_udf", {31'd0, underflow}, 32'h0);
        wr(8'h77);
        rd(8'h77);
        tick();
        tick();

        chk("sb_drained", exp_q.size(), 32'd0);
        chk("strobe_count", strobes, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Complete parametrised synchronous FIFO: read/write pointers, fill counter, status flags and sticky error flags around a dual-port memory array.
- Generalises the fixed 8x8 buffer:
  - Depth and width are parameters.
  - Adds read enable, a registered read-valid strobe, almost-full/almost-empty thresholds, an occupancy count, and overflow/underflow detection.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries.
- ALMOST_FULL_LEVEL, 6, sig_Almost_Full asserted when count >= this value; legal range 1..DEPTH.
- ALMOST_EMPTY_LEVEL, 2, sig_Almost_Empty asserted when count <= this value; legal range 0..DEPTH-1.

Ports:
- clock  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- write_Enable  input  1  write request.
- buffer_Input  input  DATA_WIDTH  write data.
- read_Enable  input  1  read request.
- buffer_Output  output  DATA_WIDTH  read data, registered.
- read_Valid  output  1  one-cycle strobe: buffer_Output updated by an accepted read.
- sig_Full  output  1  count == DEPTH.
- sig_Empty  output  1  count == 0.
- sig_Almost_Full  output  1  count >= ALMOST_FULL_LEVEL.
- sig_Almost_Empty  output  1  count <= ALMOST_EMPTY_LEVEL.
- fill_Count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.
- clear_Errors  input  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset:
  - Synchronous, active-high; wins over every other input.
  - Values: pointers=0, fill_Count=0, sig_Empty=1, sig_Full=0, sig_Almost_Full=0, sig_Almost_Empty=1, buffer_Output=0, read_Valid=0, overflow=0, underflow=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored data and any pending read_Valid.
- Write acceptance: write_Enable && !sig_Full, using flag values registered before the edge.
  - Accepted write stores buffer_Input at wr_ptr and increments wr_ptr.
- Read acceptance: read_Enable && !sig_Empty.
  - Accepted read increments rd_ptr.
  - buffer_Output <= mem[rd_ptr] at the same edge; read_Valid=1 in the following cycle.
  - Read latency is 1 cycle.
- Idle output: buffer_Output holds its last value when no read is accepted; read_Valid=0.
- Pointers wrap modulo DEPTH (natural ADDR_WIDTH-bit rollover); no special case at DEPTH-1.
- fill_Count:
  - +1 on write-only, -1 on read-only.
  - Unchanged on simultaneous accepted read+write, or when neither is accepted.
- Status flags are registered and computed from the next fill_Count value, so they are consistent with fill_Count in the same cycle.
- Full boundary:
  - write_Enable while sig_Full: write dropped, memory unchanged, overflow set.
  - A simultaneous accepted read does not free the slot for that cycle's write (count -> DEPTH-1, overflow=1).
- Empty boundary:
  - read_Enable while sig_Empty: read rejected, pointers and buffer_Output unchanged, read_Valid=0, underflow set.
  - A simultaneous write is still accepted (count -> 1).
- Same-address read/write when count>0: read returns the old word; no bypass needed, since rd_ptr==wr_ptr with count>0 only occurs when full.
- Error flags:
  - overflow/underflow remain set until reset or clear_Errors.
  - If clear_Errors and a new error occur in the same cycle, set wins.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package/header holds:
  - the default DATA_WIDTH/ADDR_WIDTH constants;
  - a DEPTH-from-ADDR_WIDTH function;
  - the flag bit-order constants for the status bus used by upstream monitors.
- One sub-module, fifo_mem_array: DEPTH x DATA_WIDTH dual-port memory with synchronous write (wr_en, wr_addr, wr_data) and registered read (rd_en, rd_addr, rd_data), no reset on storage.
- Controller logic (pointers, count, flags, errors) stays in sync_fifo_ctrl.

Test Plan:
- Reset, then idle 3 cycles -> sig_Empty=1, sig_Almost_Empty=1, fill_Count=0, buffer_Output=0, read_Valid=0.
- Write 0x11..0x18 on 8 consecutive cycles:
  - sig_Almost_Full rises when fill_Count=6.
  - sig_Full=1 and fill_Count=8 after the 8th write.
  - 9th write of 0xFF -> overflow=1, fill_Count stays 8.
- From full, read 8 consecutive cycles:
  - buffer_Output=0x11..0x18 each one cycle after its read, read_Valid high 8 cycles.
  - sig_Almost_Empty rises at count=2; sig_Empty=1 at end.
  - Extra read -> underflow=1, buffer_Output holds 0x18.
- Wrap: fill 5, drain 5, then write/read 10 words with a 2-entry backlog -> data order preserved across pointer rollover; fill_Count oscillates 1..2.
- Simultaneous read+write at count=4 -> count stays 4; at count=8 -> count 7, overflow=1; at count=0 -> count 1, underflow=1.
- Reset asserted with count=5 and read in flight -> next cycle count=0, read_Valid=0, all flags at reset values; clear_Errors pulse with a concurrent overflow -> overflow stays 1.
